// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID pipeline register with the returned word and PC+4.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_done,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_done;
    logic        w_load_valid;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_done       = (r_pc >= IMEM_LIMIT);
    assign w_load_valid = !flush && !stall && !w_done;

    // Redirect targets are forced word-aligned; a stalled cycle drops redirects
    // because the hazard unit presents them again.
    always_comb begin
        w_pc_next = r_pc;
        if (stall) begin
            w_pc_next = r_pc;
        end else if (branch_taken) begin
            w_pc_next = {branch_target[31:2], 2'b00};
        end else if (jump) begin
            w_pc_next = {jump_target[31:2], 2'b00};
        end else if (w_done) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_inst  <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (flush || (!stall && w_done)) begin
                r_inst  <= 32'd0;
                r_pc4   <= 32'd0;
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_inst  <= imem_inst;
                r_pc4   <= w_pc_plus4;
                r_valid <= 1'b1;
            end
            if (w_load_valid && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign fetch_done  = w_done;
    assign if_id_inst  = r_inst;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign fetch_count = r_count;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC and drives the byte address into the combinational instruction memory.
- Captures the returned word, with PC+4, into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect from ID, load-use stall and flush from the hazard unit, and end-of-program detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_BYTES, 256, byte size of instruction memory (64 words x 4); a PC at or above this is out of program.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
stall  input  1  hazard unit: hold PC and IF/ID contents.
flush  input  1  hazard unit: load a bubble into IF/ID.
branch_taken  input  1  ID-stage branch resolved taken.
branch_target  input  32  branch target byte address.
jump  input  1  ID-stage j/jal.
jump_target  input  32  jump target byte address.
imem_addr  output  32  current PC; drives instruction memory read_addr.
imem_inst  input  32  instruction word returned combinationally by instruction memory.
if_id_inst  output  32  IF/ID instruction.
if_id_pc4  output  32  IF/ID PC+4.
if_id_valid  output  1  IF/ID holds a real instruction.
fetch_done  output  1  current PC is out of program (combinational: pc >= IMEM_BYTES).
fetch_count  output  32  number of valid instructions loaded into IF/ID since reset.

Behaviour:
- Reset (rst_n=0 at edge) has top priority:
  - pc=RESET_PC; if_id_inst=0; if_id_pc4=0; if_id_valid=0; fetch_count=0.
  - fetch_done follows pc combinationally.
- imem_addr = pc at all times, with no register between them; imem_inst is sampled at the same edge as the PC update.
- PC next-value priority, highest first:
  1. stall=1: pc holds. branch_taken and jump are ignored that cycle; the hazard unit re-presents them.
  2. branch_taken=1: pc = {branch_target[31:2],2'b00}.
  3. jump=1: pc = {jump_target[31:2],2'b00}. If branch_taken and jump are both 1, branch wins.
  4. fetch_done=1: pc holds.
  5. Otherwise: pc = pc+4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is allowed.
- IF/ID next-value priority, highest first:
  1. flush=1: inst=0, pc4=0, valid=0. Flush beats stall.
  2. stall=1: all three fields hold.
  3. fetch_done=1: inst=0, pc4=0, valid=0 (bubble; the pipeline drains).
  4. Otherwise: inst=imem_inst, pc4=pc+4, valid=1.
- A bubble is encoded as inst 32'h0000_0000 (sll $0,$0,0); downstream needs no special decode.
- fetch_count increments by 1 exactly on edges where IF/ID loads with valid=1. It saturates at 32'hFFFF_FFFF.
- A redirect after fetch_done=1 resumes fetching normally once the new pc < IMEM_BYTES.
- A redirect to a target >= IMEM_BYTES sets fetch_done on the next cycle; no instruction from that address is captured.
- Single-cycle latency: the instruction at PC p appears on if_id_inst one edge after pc=p, when neither stall nor flush is asserted.
- No X propagation: all outputs are defined from the first edge after reset.

Test Plan:
- Reset then free run, with memory words 0..3 = A,B,C,D → after edges 1..4: if_id_inst=A,B,C,D; if_id_pc4=4,8,12,16; fetch_count=4; imem_addr=16.
- stall=1 for 2 cycles at pc=8 → pc stays 8, if_id holds B/8, fetch_count unchanged. Release → C captured with pc4=12.
- branch_taken=1, branch_target=0x22, flush=1 at pc=12 → next pc=0x20, if_id_valid=0, inst=0. Following edge: word 8 captured with pc4=0x24.
- branch_taken=1 and jump=1 together (targets 0x40, 0x80) with stall=1 → pc holds. Next cycle, stall=0 → pc=0x40 (branch wins).
- Run to pc=0xFC → word 63 captured; pc=0x100 → fetch_done=1, pc holds, IF/ID bubbles each cycle. jump to 0x10 → fetch_done=0, fetching resumes.
- Assert rst_n=0 mid-stall with if_id_valid=1 → after the edge: pc=RESET_PC, all IF/ID fields 0, fetch_count=0.
